mode_controller: RTL
====================

Name: mode_controller

Overview:
- Sequential mode sequencer that drives the mode-select flags consumed by the 7-segment display controller and the run/clear/increment controls of the clock, stopwatch and timer counters.
- Turns three push-button inputs into a registered FSM whose mode flags are one-hot by construction, so the display's conflict ('E') pattern never appears in normal operation.
- Sits between the board button inputs and the counter/display blocks.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer for each button (minimum 2).
- TIMEOUT_S, 30, idle seconds before auto-exit from time-setting mode (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_1hz  in  1  one-cycle pulse per second from the prescaler.
- btn_mode  in  1  raw mode button, active high.
- btn_set  in  1  raw set button, active high.
- btn_start  in  1  raw start/stop button, active high.
- timer_done  in  1  one-cycle pulse when the timer reaches zero.
- main_clock_active  out  1  clock-display mode flag.
- time_setting_mode  out  1  time-setting mode flag.
- stopwatch_running  out  1  stopwatch-display mode flag.
- sw_timer  out  1  timer-display mode flag.
- set_field  out  2  field being set: 0 = sec, 1 = min, 2 = hour, 3 = day.
- field_inc  out  1  one-cycle pulse: increment the selected field of the main clock.
- sw_run  out  1  stopwatch counting enable (level).
- sw_clear  out  1  one-cycle pulse: clear the stopwatch.
- timer_run  out  1  timer counting enable (level).
- timer_alarm  out  1  level; set by timer_done, cleared by any button event.

Behaviour:
- Input conditioning
  - Each button passes through a SYNC_STAGES flip-flop synchronizer, then rising-edge detection against the previous synchronized value.
  - An event is a one-cycle internal pulse.
  - An input that rises before clock edge k produces a registered output change at edge k+SYNC_STAGES (k+2 with the default).
  - Holding a button produces exactly one event.
- Event priority within one cycle: btn_mode > btn_set > btn_start. Lower-priority simultaneous events are discarded, not queued.
- Reset (async, any time including mid-operation)
  - State CLOCK, main_clock_active = 1, all other flags 0.
  - set_field = 0, sw_run = 0, timer_run = 0, timer_alarm = 0, all pulses 0, synchronizers cleared.
- FSM states: CLOCK, SET, STOPWATCH, TIMER. Mode flags are registered decodes of the state and exactly one is 1 at all times.
- CLOCK
  - mode → STOPWATCH.
  - set → SET with set_field = 0.
  - start is ignored.
- SET
  - mode: set_field increments; when set_field is 3, mode returns to CLOCK and set_field becomes 0.
  - set: field_inc pulses for 1 cycle.
  - start → CLOCK, set_field = 0.
- STOPWATCH
  - mode → TIMER. sw_run is kept, so the stopwatch continues counting in the background.
  - start toggles sw_run.
  - set with sw_run = 0 pulses sw_clear. set with sw_run = 1 is ignored.
- TIMER
  - mode → CLOCK. timer_run is kept.
  - start toggles timer_run.
  - set is ignored.
- timer_done (any state)
  - Next edge: timer_run = 0, timer_alarm = 1.
  - timer_done in the same cycle as a start event in TIMER: done wins, timer_run = 0, and the start event is consumed.
- timer_alarm clears on the cycle any button event is processed. That event still performs its normal action.
- Pulse outputs (field_inc, sw_clear) are registered, one cycle wide, and never back-to-back from a single press.
- tick_1hz is used only by the optional feature.

Optional Feature:
- Macro MODE_TIMEOUT_EN.
- Defined:
  - An idle counter, width clog2(TIMEOUT_S+1), counts tick_1hz pulses while in SET.
  - The counter is cleared by any button event and on entry to SET.
  - When it reaches TIMEOUT_S, the FSM goes to CLOCK and set_field = 0 on the next edge.
  - A button event in the same cycle takes priority and resets the counter.
- Undefined: no counter; SET is left only by a button.

Decomposition:
- Package mode_pkg holds:
  - the state enum (CLOCK = 0, SET = 1, STOPWATCH = 2, TIMER = 3);
  - field constants FIELD_SEC..FIELD_DAY;
  - default SYNC_STAGES and TIMEOUT_S.
- Sub-module btn_sync_edge (synchronizer + rising-edge pulse, parameter SYNC_STAGES), instantiated three times.
- FSM, run/alarm registers and timeout counter live in the top module.

Test Plan:
- Reset then release, no buttons: main_clock_active = 1, other flags 0, set_field = 0, sw_run = 0, timer_run = 0, all held for 100 cycles.
- From CLOCK, btn_mode pressed 3 times: flags go STOPWATCH → TIMER → CLOCK, each change exactly 2 cycles after the press; one-hot checked every cycle.
- SET entry and field stepping: set, set, set, mode, set → field_inc pulses 2 times at field 0 and once at field 1. Then mode ×3 returns to CLOCK with set_field = 0.
- STOPWATCH:
  - start → sw_run = 1; set → no sw_clear;
  - start → sw_run = 0; set → sw_clear pulses once for 1 cycle.
- TIMER: start → timer_run = 1. timer_done coincident with a start event → timer_run = 0, timer_alarm = 1. Next mode press → alarm cleared and state CLOCK.
- With MODE_TIMEOUT_EN and TIMEOUT_S = 3: enter SET, send 3 tick_1hz → CLOCK. Repeat with a set press after tick 2 → stays in SET until 3 further ticks.

Source files
------------

// File: rtl/mode_pkg.sv
// ---------------------------------------------------------------------------
// mode_pkg
// Shared types and constants for the mode sequencer: FSM state encoding,
// set-field codes and default parameter values.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mode_pkg;

  typedef enum logic [1:0] {
    CLOCK     = 2'd0,
    SET       = 2'd1,
    STOPWATCH = 2'd2,
    TIMER     = 2'd3
  } mode_state_e;

  localparam logic [1:0] FIELD_SEC  = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_HOUR = 2'd2;
  localparam logic [1:0] FIELD_DAY  = 2'd3;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_TIMEOUT_S   = 30;

endpackage : mode_pkg

`default_nettype wire

// File: rtl/btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Multi-stage synchronizer for an asynchronous button followed by a
// rising-edge detector that emits a single-cycle pulse per press.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw button through the synchronizer and keep the last settled value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pulse is combinational so the consumer registers its reaction SYNC_STAGES edges after the input rise.
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : btn_sync_edge

`default_nettype wire

// File: rtl/mode_controller.sv
// ---------------------------------------------------------------------------
// mode_controller
// Button-driven mode sequencer for the clock / stopwatch / timer display.
// Produces one-hot registered mode flags, run levels and single-cycle
// control pulses. Optional feature: define MODE_TIMEOUT_EN to leave SET
// automatically after TIMEOUT_S idle seconds.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mode_controller
  import mode_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_S   = DEFAULT_TIMEOUT_S
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_start,
  input  logic       timer_done,
  output logic       main_clock_active,
  output logic       time_setting_mode,
  output logic       stopwatch_running,
  output logic       sw_timer,
  output logic [1:0] set_field,
  output logic       field_inc,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       timer_run,
  output logic       timer_alarm
);

  logic rise_mode, rise_set, rise_start;
  logic ev_mode, ev_set, ev_start, any_ev;

  mode_state_e state_q, state_d;
  logic [1:0]  set_field_q, set_field_d;
  logic        sw_run_q, sw_run_d;
  logic        timer_run_q, timer_run_d;
  logic        alarm_q, alarm_d;
  logic        field_inc_q, field_inc_d;
  logic        sw_clear_q, sw_clear_d;
  logic        clock_flag_q, set_flag_q, sw_flag_q, timer_flag_q;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mode (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_mode), .rise_o(rise_mode)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_set (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_set), .rise_o(rise_set)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_start), .rise_o(rise_start)
  );

  // Only the highest-priority event of a cycle acts; the others are dropped.
  assign ev_mode  = rise_mode;
  assign ev_set   = rise_set & ~rise_mode;
  assign ev_start = rise_start & ~rise_mode & ~rise_set;
  assign any_ev   = rise_mode | rise_set | rise_start;

`ifdef MODE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_hit;

  assign timeout_hit = (state_q == SET) && !any_ev && (idle_q == IDLE_W'(TIMEOUT_S));

  // Idle seconds in SET; held at zero elsewhere so entry to SET starts fresh.
  always_comb begin
    idle_d = idle_q;
    if (state_q != SET || any_ev || timeout_hit) begin
      idle_d = '0;
    end else if (tick_1hz) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic timeout_hit;
  logic unused_inputs;
  assign timeout_hit   = 1'b0;
  assign unused_inputs = tick_1hz ^ (TIMEOUT_S != 0);
`endif

  // Next-state and next-output decode; timer_done overrides any start toggle.
  always_comb begin
    state_d     = state_q;
    set_field_d = set_field_q;
    sw_run_d    = sw_run_q;
    timer_run_d = timer_run_q;
    alarm_d     = alarm_q;
    field_inc_d = 1'b0;
    sw_clear_d  = 1'b0;
    case (state_q)
      CLOCK: begin
        if (ev_mode) begin
          state_d = STOPWATCH;
        end else if (ev_set) begin
          state_d     = SET;
          set_field_d = FIELD_SEC;
        end
      end
      SET: begin
        if (ev_mode) begin
          if (set_field_q == FIELD_DAY) begin
            state_d     = CLOCK;
            set_field_d = FIELD_SEC;
          end else begin
            set_field_d = set_field_q + 2'd1;
          end
        end else if (ev_set) begin
          field_inc_d = 1'b1;
        end else if (ev_start || timeout_hit) begin
          state_d     = CLOCK;
          set_field_d = FIELD_SEC;
        end
      end
      STOPWATCH: begin
        if (ev_mode) begin
          state_d = TIMER;
        end else if (ev_set) begin
          sw_clear_d = ~sw_run_q;
        end else if (ev_start) begin
          sw_run_d = ~sw_run_q;
        end
      end
      TIMER: begin
        if (ev_mode) begin
          state_d = CLOCK;
        end else if (ev_start) begin
          timer_run_d = ~timer_run_q;
        end
      end
      default: state_d = CLOCK;
    endcase
    if (any_ev) alarm_d = 1'b0;
    if (timer_done) begin
      timer_run_d = 1'b0;
      alarm_d     = 1'b1;
    end
  end

  // FSM state plus registered mode flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLOCK;
      set_field_q  <= FIELD_SEC;
      sw_run_q     <= 1'b0;
      timer_run_q  <= 1'b0;
      alarm_q      <= 1'b0;
      field_inc_q  <= 1'b0;
      sw_clear_q   <= 1'b0;
      clock_flag_q <= 1'b1;
      set_flag_q   <= 1'b0;
      sw_flag_q    <= 1'b0;
      timer_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      set_field_q  <= set_field_d;
      sw_run_q     <= sw_run_d;
      timer_run_q  <= timer_run_d;
      alarm_q      <= alarm_d;
      field_inc_q  <= field_inc_d;
      sw_clear_q   <= sw_clear_d;
      clock_flag_q <= (state_d == CLOCK);
      set_flag_q   <= (state_d == SET);
      sw_flag_q    <= (state_d == STOPWATCH);
      timer_flag_q <= (state_d == TIMER);
    end
  end

  assign main_clock_active = clock_flag_q;
  assign time_setting_mode = set_flag_q;
  assign stopwatch_running = sw_flag_q;
  assign sw_timer          = timer_flag_q;
  assign set_field         = set_field_q;
  assign field_inc         = field_inc_q;
  assign sw_run            = sw_run_q;
  assign sw_clear          = sw_clear_q;
  assign timer_run         = timer_run_q;
  assign timer_alarm       = alarm_q;

endmodule : mode_controller

`default_nettype wire
